result_demux4: RTL

RESULT_DEMUX4 -- requirements
Module: result_demux4

---
 rtl/calc_pkg.sv | 10 +
 rtl/demux_slot.sv | 43 ++++
 rtl/result_demux4.sv | 88 ++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the result demultiplexer.
package calc_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned DROP_MAX      = 15;

  typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel: data register plus valid bit, written on an accepted write and
// cleared when its consumer acknowledges.
module demux_slot #(
  parameter int unsigned WIDTH = calc_pkg::DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] y_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             vld_q, vld_d;

  // A write wins over a same-cycle ack so the new word stays valid.
  always_comb begin
    y_d   = y_q;
    vld_d = vld_q;
    if (wr_i) begin
      y_d   = d_i;
      vld_d = 1'b1;
    end else if (ack_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign y_o   = y_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/result_demux4.sv
// Routes a data word to one of four registered channels selected by {s2,s1}; writes to a
// full, unacknowledged channel are dropped and counted.
module result_demux4
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s2,
  input  logic             s1,
  input  logic             en,
  input  logic [3:0]       ack,
  output logic             rdy,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       vld,
  output logic             ovf,
  output logic [3:0]       drop_cnt
);

  ch_idx_t    idx;
  logic [3:0] sel;
  logic [3:0] wr;
  logic       drop;

  logic       ovf_q, ovf_d;
  logic [3:0] cnt_q, cnt_d;

  assign idx = {s2, s1};

  always_comb begin
    sel = 4'b0000;
    unique case (idx)
      2'd0: sel = 4'b0001;
      2'd1: sel = 4'b0010;
      2'd2: sel = 4'b0100;
      2'd3: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
  end

  // A channel drained by its consumer this cycle can be refilled on the same edge.
  assign rdy  = ~vld[idx] | ack[idx];
  assign wr   = sel & {4{en & rdy}};
  assign drop = en & ~rdy;

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk_i(clk), .rst_i(rst), .wr_i(wr[0]), .ack_i(ack[0]), .d_i(d), .y_o(y0), .vld_o(vld[0])
  );
  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk_i(clk), .rst_i(rst), .wr_i(wr[1]), .ack_i(ack[1]), .d_i(d), .y_o(y1), .vld_o(vld[1])
  );
  demux_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk_i(clk), .rst_i(rst), .wr_i(wr[2]), .ack_i(ack[2]), .d_i(d), .y_o(y2), .vld_o(vld[2])
  );
  demux_slot #(.WIDTH(WIDTH)) u_slot3 (
    .clk_i(clk), .rst_i(rst), .wr_i(wr[3]), .ack_i(ack[3]), .d_i(d), .y_o(y3), .vld_o(vld[3])
  );

  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != 4'(DROP_MAX)) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = cnt_q;

endmodule
